// File: rtl/hilo_muldiv.sv
// -----------------------------------------------------------------------------
// hilo_muldiv
//   Multi-cycle unsigned multiply/divide unit that sits in the EX stage beside
//   the single-cycle ALU. It owns the HI/LO register pair and executes the
//   funct codes the ALU leaves alone: MULTU, DIVU, MFHI and MFLO.
//   MULTU/DIVU take one iteration per cycle for WIDTH cycles; busy tells the
//   hazard unit to hold IF/ID/EX while an operation is in flight.
//
// Ports
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-low reset
//   start    in   EX presents a muldiv-class instruction this cycle
//   Signal   in   6-bit funct code (MULTU=25, DIVU=27, MFHI=16, MFLO=18)
//   dataA    in   rs operand: multiplicand / dividend
//   dataB    in   rt operand: multiplier / divisor
//   busy     out  registered; operation in flight, start not accepted
//   done     out  one-cycle pulse, HI/LO were just written
//   dataOut  out  registered MFHI/MFLO result
//   hi, lo   out  HI and LO registers
// -----------------------------------------------------------------------------
module hilo_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       Signal,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dataOut,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [5:0] F_MFHI  = 6'd16;
    localparam logic [5:0] F_MFLO  = 6'd18;
    localparam logic [5:0] F_MULTU = 6'd25;
    localparam logic [5:0] F_DIVU  = 6'd27;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_a;     // multiplicand (MUL) / divisor is r_b (DIV)
    logic [WIDTH-1:0]   r_b;     // MUL: multiplier, low product bits shift in from the top
    logic [WIDTH-1:0]   r_acc;   // MUL: upper half of the product accumulator
    logic [WIDTH-1:0]   r_rem;   // DIV: partial remainder
    logic [WIDTH-1:0]   r_quot;  // DIV: dividend bits shifting out, quotient bits shifting in

    logic               w_accept;
    logic               w_last;
    logic [WIDTH:0]     w_madd;
    logic [WIDTH-1:0]   w_mlo_nx;
    logic [WIDTH:0]     w_rem_sh;
    logic               w_ge;
    logic [WIDTH-1:0]   w_rem_nx;
    logic [WIDTH-1:0]   w_quot_nx;

    assign w_accept = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

    // Shift-add step: the 64-bit accumulator is {r_acc, r_b}. The multiplier
    // occupies the low half and is consumed LSB-first while product bits
    // enter from the top, so the whole product is {r_acc, r_b} after WIDTH steps.
    // The add is WIDTH+1 bits wide so the carry lands in the shifted result.
    assign w_madd   = {1'b0, r_acc} + (r_b[0] ? {1'b0, r_a} : '0);
    assign w_mlo_nx = {w_madd[0], r_b[WIDTH-1:1]};

    // Restoring step. The shifted remainder needs WIDTH+1 bits (it can reach
    // 2*b-1); when it is >= b the difference is < b, so WIDTH bits hold it.
    assign w_rem_sh  = {r_rem, r_quot[WIDTH-1]};
    assign w_ge      = (w_rem_sh >= {1'b0, r_b});
    assign w_rem_nx  = w_ge ? (w_rem_sh[WIDTH-1:0] - r_b) : w_rem_sh[WIDTH-1:0];
    assign w_quot_nx = {r_quot[WIDTH-2:0], w_ge};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_rem   <= '0;
            r_quot  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            dataOut <= '0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_MUL: begin
                    r_acc <= w_madd[WIDTH:1];
                    r_b   <= w_mlo_nx;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        hi      <= w_madd[WIDTH:1];
                        lo      <= w_mlo_nx;
                        r_cnt   <= '0;
                        r_state <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                S_DIV: begin
                    r_rem  <= w_rem_nx;
                    r_quot <= w_quot_nx;
                    r_cnt  <= r_cnt + 1'b1;
                    if (w_last) begin
                        hi      <= w_rem_nx;
                        lo      <= w_quot_nx;
                        r_cnt   <= '0;
                        r_state <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE both accept; DONE falls back to IDLE
                    // unless a new multi-cycle operation starts.
                    r_state <= S_IDLE;
                    if (w_accept) begin
                        case (Signal)
                            F_MULTU: begin
                                r_a     <= dataA;
                                r_b     <= dataB;
                                r_acc   <= '0;
                                r_cnt   <= '0;
                                r_state <= S_MUL;
                                busy    <= 1'b1;
                            end
                            F_DIVU: begin
                                r_a     <= dataA;
                                r_b     <= dataB;
                                r_rem   <= '0;
                                r_quot  <= dataA;
                                r_cnt   <= '0;
                                r_state <= S_DIV;
                                busy    <= 1'b1;
                            end
                            F_MFHI:  dataOut <= hi;
                            F_MFLO:  dataOut <= lo;
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule
